// File: rtl/pwl_pkg.sv
// Shared Q2.13 constants and FSM encoding
// for the piecewise-linear jerk integrator.
package pwl_pkg;

  localparam int WL = 16;
  localparam int FL = 13;

  localparam logic [WL-1:0] ONE   = 16'h2000;
  localparam logic [WL-1:0] MAX_Q = 16'h7FFF;
  localparam logic [WL-1:0] MIN_Q = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    UPDATE,
    DONE
  } state_t;

  // |v| in Q2.13; the most negative code maps
  // to the most positive one instead of itself
  function automatic logic [WL-1:0] abs_q(
    input logic [WL-1:0] v
  );
    if (v == MIN_Q)
      return MAX_Q;
    else if (v[WL-1])
      return -v;
    else
      return v;
  endfunction

endpackage

// File: rtl/sat_reduce.sv
// Narrows an N-bit signed sum to Q2.13 and flags overflow.
// Build option: SATURATE_EN clamps instead of wrapping.
module sat_reduce
  import pwl_pkg::*;
#(
  parameter int N = 18
) (
  input  logic signed [N-1:0] din,
  output logic [WL-1:0]       dout,
  output logic                ovf
);

  logic [N-WL:0] hi;

  assign hi = din[N-1:WL-1];

  // In range only when all bits above the 16-bit
  // sign position agree with it
  always_comb begin
    ovf = !((&hi) || (~|hi));
`ifdef SATURATE_EN
    if (ovf)
      dout = din[N-1] ? MIN_Q : MAX_Q;
    else
      dout = din[WL-1:0];
`else
    dout = din[WL-1:0];
`endif
  end

endmodule

// File: rtl/pwl_euler_step.sv
// Forward-Euler step of x'=y, y'=z, z'=-Az-y+|x|-1 in Q2.13.
// Build option: SATURATE_EN selects clamping reductions.
module pwl_euler_step
  import pwl_pkg::*;
#(
  parameter int          H_SHIFT = 6,
  parameter logic [15:0] X0      = 16'h0000,
  parameter logic [15:0] Y0      = 16'h0000,
  parameter logic [15:0] Z0      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] AZ_IN,
  output logic [15:0] Z_A_OUT,
  output logic [15:0] X_OUT,
  output logic [15:0] Y_OUT,
  output logic [15:0] Z_OUT,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  state_t state;
  state_t state_nxt;

  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] z_q;
  logic [15:0] dx_q;
  logic [15:0] dy_q;
  logic [15:0] dz_q;
  logic        dz_ovf_q;
  logic        ovf_q;

  logic [15:0] ax;
  logic [17:0] ax_e;
  logic [17:0] az_e;
  logic [17:0] y_e;
  logic [17:0] one_e;

  logic signed [17:0] dz_sum;
  logic [15:0]        dz_red;
  logic               dz_ovf;

  logic signed [15:0] sx;
  logic signed [15:0] sy;
  logic signed [15:0] sz;

  logic signed [16:0] x_sum;
  logic signed [16:0] y_sum;
  logic signed [16:0] z_sum;

  logic [15:0] x_red;
  logic [15:0] y_red;
  logic [15:0] z_red;
  logic        x_ovf;
  logic        y_ovf;
  logic        z_ovf;

  // Derivative of z at 18 bits so no term can wrap
  assign ax     = abs_q(x_q);
  assign ax_e   = {{2{ax[15]}}, ax};
  assign az_e   = {{2{AZ_IN[15]}}, AZ_IN};
  assign y_e    = {{2{y_q[15]}}, y_q};
  assign one_e  = {2'b00, ONE};
  assign dz_sum = ax_e - az_e - y_e - one_e;

  sat_reduce #(.N(18)) u_red_dz (
    .din  (dz_sum),
    .dout (dz_red),
    .ovf  (dz_ovf)
  );

  // Step size h = 2^-H_SHIFT as an arithmetic shift
  assign sx = $signed(dx_q) >>> H_SHIFT;
  assign sy = $signed(dy_q) >>> H_SHIFT;
  assign sz = $signed(dz_q) >>> H_SHIFT;

  assign x_sum = {x_q[15], x_q} + {sx[15], sx};
  assign y_sum = {y_q[15], y_q} + {sy[15], sy};
  assign z_sum = {z_q[15], z_q} + {sz[15], sz};

  sat_reduce #(.N(17)) u_red_x (
    .din  (x_sum),
    .dout (x_red),
    .ovf  (x_ovf)
  );

  sat_reduce #(.N(17)) u_red_y (
    .din  (y_sum),
    .dout (y_red),
    .ovf  (y_ovf)
  );

  sat_reduce #(.N(17)) u_red_z (
    .din  (z_sum),
    .dout (z_red),
    .ovf  (z_ovf)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state; clr aborts from anywhere
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    state_nxt = UPDATE;
        UPDATE:  state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Latch derivatives in CALC, commit state in UPDATE.
  // The dz overflow is held back so ovf moves with
  // the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= X0;
      y_q      <= Y0;
      z_q      <= Z0;
      dx_q     <= '0;
      dy_q     <= '0;
      dz_q     <= '0;
      dz_ovf_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      x_q      <= X0;
      y_q      <= Y0;
      z_q      <= Z0;
      dz_ovf_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == CALC) begin
        dx_q     <= y_q;
        dy_q     <= z_q;
        dz_q     <= dz_red;
        dz_ovf_q <= dz_ovf;
      end
      if (state == UPDATE) begin
        x_q   <= x_red;
        y_q   <= y_red;
        z_q   <= z_red;
        ovf_q <= ovf_q | dz_ovf_q | x_ovf | y_ovf | z_ovf;
      end
    end
  end

  assign X_OUT   = x_q;
  assign Y_OUT   = y_q;
  assign Z_OUT   = z_q;
  assign Z_A_OUT = z_q;
  assign busy    = (state == CALC) || (state == UPDATE);
  assign done    = (state == DONE);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pwl_euler_step.sv
// Bench for pwl_euler_step: three parameterisations
// driven together and checked against a step-level model.
module tb_pwl_euler_step;

  logic clk;
  logic rst;
  logic clr;
  logic start;
  logic mode;
  logic [15:0] az_rand;
  logic chk_en;

  logic [15:0] az [3];
  logic [15:0] za [3];
  logic [15:0] xo [3];
  logic [15:0] yo [3];
  logic [15:0] zo [3];
  logic        bo [3];
  logic        dn [3];
  logic        ov [3];

  int hs [3] = '{6, 6, 0};
  int ix [3] = '{0, -32768, 32752};
  int iy [3] = '{0, 0, 32767};
  int iz [3] = '{0, 0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  int mx [3];
  int my [3];
  int mz [3];
  int mo [3];
  int maz [3];
  int age;

  localparam logic signed [15:0] A_COEF = 16'sh1333;

  // Stand-in for scm_a: A*z in Q2.13, truncated
  function automatic logic [15:0] scm(input logic [15:0] z);
    logic signed [31:0] p;
    p = $signed(z) * A_COEF;
    return p[28:13];
  endfunction

  function automatic int red(input int v, output int o);
    logic [15:0] t;
    o = (v > 32767 || v < -32768) ? 1 : 0;
`ifdef SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = v[15:0];
    return int'($signed(t));
`endif
  endfunction

  task automatic step(input int i);
    int ax, dz, nx, ny, nz, o1, o2, o3, o4;
    if (mx[i] == -32768) ax = 32767;
    else if (mx[i] < 0) ax = -mx[i];
    else ax = mx[i];
    dz = red(-maz[i] - my[i] + ax - 8192, o1);
    nx = red(mx[i] + (my[i] >>> hs[i]), o2);
    ny = red(my[i] + (mz[i] >>> hs[i]), o3);
    nz = red(mz[i] + (dz >>> hs[i]), o4);
    mx[i] = nx;
    my[i] = ny;
    mz[i] = nz;
    if (o1 + o2 + o3 + o4 != 0) mo[i] = 1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 3; i++) begin
      mx[i] = ix[i];
      my[i] = iy[i];
      mz[i] = iz[i];
      mo[i] = 0;
    end
    age = -1;
  endtask

  task automatic check(input string nm, input int act,
                       input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  pwl_euler_step u0 (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .AZ_IN(az[0]), .Z_A_OUT(za[0]),
    .X_OUT(xo[0]), .Y_OUT(yo[0]), .Z_OUT(zo[0]),
    .busy(bo[0]), .done(dn[0]), .ovf(ov[0])
  );

  pwl_euler_step #(.X0(16'h8000)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .AZ_IN(az[1]), .Z_A_OUT(za[1]),
    .X_OUT(xo[1]), .Y_OUT(yo[1]), .Z_OUT(zo[1]),
    .busy(bo[1]), .done(dn[1]), .ovf(ov[1])
  );

  pwl_euler_step #(
    .H_SHIFT(0), .X0(16'h7FF0), .Y0(16'h7FFF)
  ) u2 (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .AZ_IN(az[2]), .Z_A_OUT(za[2]),
    .X_OUT(xo[2]), .Y_OUT(yo[2]), .Z_OUT(zo[2]),
    .busy(bo[2]), .done(dn[2]), .ovf(ov[2])
  );

  assign az[0] = mode ? scm(za[0]) : az_rand;
  assign az[1] = mode ? scm(za[1]) : az_rand;
  assign az[2] = mode ? scm(za[2]) : az_rand;

  always #5 clk = ~clk;

  // Step-level model: accept, sample A*z, then apply the step
  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      model_init();
    end else if (age == -1) begin
      if (start) age = 1;
    end else if (age == 1) begin
      for (int i = 0; i < 3; i++)
        maz[i] = mode ? int'($signed(scm(16'(mz[i]))))
                      : int'($signed(az_rand));
      age = 2;
    end else if (age == 2) begin
      for (int i = 0; i < 3; i++) step(i);
      age = 3;
    end else begin
      age = -1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("x%0d", i), int'($signed(xo[i])), mx[i]);
        check($sformatf("y%0d", i), int'($signed(yo[i])), my[i]);
        check($sformatf("z%0d", i), int'($signed(zo[i])), mz[i]);
        check($sformatf("za%0d", i), int'($signed(za[i])), mz[i]);
        check($sformatf("busy%0d", i), int'(bo[i]),
              (age == 1 || age == 2) ? 1 : 0);
        check($sformatf("done%0d", i), int'(dn[i]),
              (age == 3) ? 1 : 0);
        check($sformatf("ovf%0d", i), int'(ov[i]), mo[i]);
      end
    end
  end

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    clk = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    start = 1'b0;
    mode = 1'b1;
    az_rand = '0;
    chk_en = 1'b0;
    model_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    check("rst_x1", int'(xo[1]), 'h8000);
    check("rst_y2", int'(yo[2]), 'h7FFF);
    check("rst_busy", int'(bo[0]), 0);
    check("rst_ovf", int'(ov[2]), 0);

    // single step, literal results
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_busy1", int'(bo[0]), 1);
    @(negedge clk);
    check("lat_busy2", int'(bo[0]), 1);
    check("lat_zhold", int'(zo[0]), 0);
    @(negedge clk);
    check("lat_done", int'(dn[0]), 1);
    check("def_z", int'(zo[0]), 'hFF80);
    check("def_x", int'(xo[0]), 0);
    check("absmin_z", int'(zo[1]), 'h017F);
    check("absmin_ovf", int'(ov[1]), 0);
`ifdef SATURATE_EN
    check("sat_x", int'(xo[2]), 'h7FFF);
`else
    check("wrap_x", int'(xo[2]), 'hFFEF);
`endif
    check("big_ovf", int'(ov[2]), 1);
    check("big_z", int'(zo[2]), 'hDFF1);
    @(negedge clk);
    check("done_once", int'(dn[0]), 0);

    // starts in CALC and with done are ignored
    do_clr();
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      start = (k == 0 || k == 1 || k == 3);
      @(negedge clk);
      if (dn[0]) cnt++;
    end
    start = 1'b0;
    check("ign_done_cnt", cnt, 1);
    check("ign_z", int'(zo[0]), 'hFF80);

    // clr during UPDATE aborts
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", int'(bo[0]), 0);
    check("clr_done", int'(dn[0]), 0);
    check("clr_z", int'(zo[0]), 0);
    check("clr_x2", int'(xo[2]), 'h7FF0);
    check("clr_ovf2", int'(ov[2]), 0);
    @(negedge clk);
    check("clr_nodone", int'(dn[0]), 0);

    // async reset during CALC
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(bo[0]), 0);
    check("arst_x1", int'(xo[1]), 'h8000);
    check("arst_done", int'(dn[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (dn[0]) seen = 1;
    end
    check("arst_restart", int'(seen), 1);
    check("arst_z", int'(zo[0]), 'hFF80);

    // randomized traffic
    repeat (800) begin
      start = ($urandom % 3 == 0);
      clr = ($urandom % 25 == 0);
      az_rand = 16'($urandom);
      if ($urandom % 40 == 0) mode = ~mode;
      @(negedge clk);
    end
    start = 1'b0;
    clr = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
